rr_arbiter_timeslice: RTL and testbench

- Parametrised N-way round-robin arbiter; each grant is held for a programmable number of cycles (time slice) before the next arbitration.
- Successor to the fixed 4-requester, one-cycle-slice arbiter.
- Sits in front of shared resources (bus ports, memory banks) and drives one-hot registered grants with an encoded grant index.

---
 rtl/rr_arbiter_timeslice.sv | 104 ++++++++++
 tb/tb_rr_arbiter_timeslice.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_timeslice.sv
// N-way round-robin arbiter; each grant is held for a programmable time slice.
// Optional: define RR_ARB_EARLY_RELEASE_EN to end a slice when the holder drops its request.
module rr_arbiter_timeslice #(
  parameter int N       = 4,
  parameter int SLICE_W = 4,
  parameter int IDW     = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       req,
  input  logic [SLICE_W-1:0] slice_len,
  output logic [N-1:0]       gnt,
  output logic [IDW-1:0]     gnt_id,
  output logic               gnt_valid,
  output logic               slice_last
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state;
  logic [IDW-1:0]     last;
  logic [SLICE_W-1:0] cnt;
  logic [IDW-1:0]     pick;
  logic               found;
  logic [IDW:0]       sum;
  logic [IDW-1:0]     idx;
  logic [SLICE_W-1:0] eff_len;

  // Search upward from last+1 with wrap; the first hit wins, so the previous holder
  // is checked last and only wins when it is the sole requester.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      sum = {1'b0, last} + (IDW+1)'(i);
      if (sum >= (IDW+1)'(N))
        sum = sum - (IDW+1)'(N);
      idx = sum[IDW-1:0];
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign eff_len = (slice_len == '0) ? SLICE_W'(1) : slice_len;

  always_comb begin
    slice_last = 1'b0;
    if (state == GRANT) begin
`ifdef RR_ARB_EARLY_RELEASE_EN
      slice_last = (cnt == SLICE_W'(1)) || !req[gnt_id];
`else
      slice_last = (cnt == SLICE_W'(1));
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
      last      <= IDW'(N-1);
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state     <= GRANT;
            gnt       <= N'(1) << pick;
            gnt_id    <= pick;
            gnt_valid <= 1'b1;
            last      <= pick;
            cnt       <= eff_len;
          end
        end
        GRANT: begin
          if (slice_last) begin
            if (found) begin
              gnt       <= N'(1) << pick;
              gnt_id    <= pick;
              gnt_valid <= 1'b1;
              last      <= pick;
              cnt       <= eff_len;
            end else begin
              state     <= IDLE;
              gnt       <= '0;
              gnt_valid <= 1'b0;
              cnt       <= '0;
            end
          end else begin
            cnt <= cnt - SLICE_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter_timeslice.sv
// Randomised self-checking bench for rr_arbiter_timeslice against a slice-level reference model.
module tb_rr_arbiter_timeslice;
  localparam int N = 4;
  localparam int SLICE_W = 4;
  localparam int IDW = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [N-1:0]       req = '0;
  logic [SLICE_W-1:0] slice_len = '0;
  logic [N-1:0]       gnt;
  logic [IDW-1:0]     gnt_id;
  logic               gnt_valid;
  logic               slice_last;

  int total = 0;
  int bad = 0;

  // Reference model: who holds the resource, cycles left in the slice, last winner.
  bit m_busy;
  int m_holder;
  int m_rem;
  int m_last;

  rr_arbiter_timeslice #(.N(N), .SLICE_W(SLICE_W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .slice_len(slice_len),
    .gnt(gnt), .gnt_id(gnt_id), .gnt_valid(gnt_valid), .slice_last(slice_last)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_busy = 0; m_holder = 0; m_rem = 0; m_last = N - 1;
  endfunction

  function automatic bit early_rel(input logic [N-1:0] r);
`ifdef RR_ARB_EARLY_RELEASE_EN
    return m_busy && !r[m_holder];
`else
    return 1'b0;
`endif
  endfunction

  function automatic void model_edge(input logic [N-1:0] r, input int len);
    bit decide;
    bit hit;
    decide = !m_busy || m_rem == 1 || early_rel(r);
    if (!decide) begin
      m_rem = m_rem - 1;
      return;
    end
    hit = 0;
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (m_last + k) % N;
      if (!hit && r[c]) begin
        hit = 1; m_holder = c; m_last = c;
        m_rem = (len == 0) ? 1 : len;
        m_busy = 1;
      end
    end
    if (!hit) begin
      m_busy = 0; m_rem = 0;
    end
  endfunction

  task automatic compare(input string name);
    logic [N-1:0] eg;
    logic         esl;
    eg  = m_busy ? (N'(1) << m_holder) : '0;
    esl = m_busy && (m_rem == 1 || early_rel(req));
    total++;
    if (gnt !== eg) begin
      bad++; $display("FAIL %s gnt got=%b want=%b", name, gnt, eg);
    end
    total++;
    if (gnt_id !== IDW'(m_holder)) begin
      bad++; $display("FAIL %s gnt_id got=%0d want=%0d", name, gnt_id, m_holder);
    end
    total++;
    if (gnt_valid !== m_busy) begin
      bad++; $display("FAIL %s gnt_valid got=%b want=%b", name, gnt_valid, m_busy);
    end
    total++;
    if (slice_last !== esl) begin
      bad++; $display("FAIL %s slice_last got=%b want=%b", name, slice_last, esl);
    end
  endtask

  // Drive inputs, clock one edge, advance the model, check just after the edge.
  task automatic step(input logic [N-1:0] r, input int len, input string name);
    req = r;
    slice_len = SLICE_W'(len);
    @(posedge clk);
    model_edge(r, len);
    #1;
    compare(name);
  endtask

  task automatic test_reset();
    model_reset();
    rst_n = 1'b0;
    req = '0;
    #12;
    compare("reset_hold");
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step('0, 3, "reset_idle");
  endtask

  task automatic test_rotation();
    for (int i = 0; i < 15; i++) step(4'b1111, 3, "rotation");
    for (int i = 0; i < 4; i++) step(4'b0000, 3, "rotation_drain");
  endtask

  task automatic test_sole();
    for (int i = 0; i < 7; i++) step(4'b0100, 2, "sole");
    for (int i = 0; i < 4; i++) step(4'b0000, 2, "sole_drop");
  endtask

  task automatic test_zero_len_change();
    for (int i = 0; i < 5; i++) step(4'b1111, 0, "zero_len");
    for (int i = 0; i < 2; i++) step(4'b0000, 0, "zero_len_drain");
    step(4'b0011, 5, "len_change_issue");
    for (int i = 0; i < 8; i++) step(4'b0011, 1, "len_change");
    for (int i = 0; i < 2; i++) step(4'b0000, 1, "len_change_drain");
  endtask

  task automatic test_async_reset();
    step(4'b0011, 7, "areset_issue");
    step(4'b0011, 7, "areset_c2");
    step(4'b0011, 7, "areset_c3");
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if (gnt !== '0 || gnt_valid !== 1'b0 || slice_last !== 1'b0) begin
      bad++;
      $display("FAIL areset_immediate gnt=%b valid=%b last=%b want 0/0/0", gnt, gnt_valid, slice_last);
    end
    #3;
    rst_n = 1'b1;
    step(4'b0011, 7, "areset_first");
    total++;
    if (gnt !== 4'b0001) begin
      bad++; $display("FAIL areset_first_grant got=%b want=0001", gnt);
    end
    for (int i = 0; i < 8; i++) step(4'b0000, 7, "areset_drain");
  endtask

  task automatic test_early_release();
    rst_n = 1'b0;
    model_reset();
    #3;
    rst_n = 1'b1;
    step(4'b0011, 8, "early_issue");
    step(4'b0011, 8, "early_c2");
    step(4'b0010, 8, "early_drop");
    total++;
`ifdef RR_ARB_EARLY_RELEASE_EN
    if (gnt !== 4'b0010) begin
      bad++; $display("FAIL early_switch got=%b want=0010", gnt);
    end
`else
    if (gnt !== 4'b0001) begin
      bad++; $display("FAIL early_hold got=%b want=0001", gnt);
    end
`endif
    for (int i = 0; i < 10; i++) step(4'b0010, 8, "early_tail");
    for (int i = 0; i < 10; i++) step(4'b0000, 8, "early_drain");
  endtask

  task automatic test_random();
    logic [N-1:0] r;
    int len;
    int hold;
    hold = 0;
    r = '0;
    len = 0;
    for (int i = 0; i < 400; i++) begin
      if (hold == 0) begin
        r = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom_range(0, 15));
        hold = $urandom_range(0, 6);
      end else begin
        hold--;
      end
      len = $urandom_range(0, 15);
      step(r, len, "random");
    end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_sole();
    test_zero_len_change();
    test_async_reset();
    test_early_release();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
